// File: rtl/mem_bridge_pkg.sv
// Shared types and widths for the MMU-to-DRAM memory bridge.
package mem_bridge_pkg;

  // Midgard cache-line number width (64-bit address, 64-byte lines).
  localparam int MCN_W = 64 - 6;

  // Out-of-range request counter width and its saturation value.
  localparam int ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Per-transaction bookkeeping carried alongside the index in the tracker.
  // A tracker entry is {idx, trk_meta_t}; idx width is a module parameter.
  typedef struct packed {
    logic rnw;
    logic err;
  } trk_meta_t;

  localparam int TRK_META_W = $bits(trk_meta_t);

endpackage

// File: rtl/mem_bridge_fifo.sv
// Synchronous FIFO with first-word-fall-through head; DEPTH must be a power of two >= 2.
module mem_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointer arithmetic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO and ignores pushes during reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mem_bridge.sv
// Bridges MMU line requests to backing DRAM, answering out-of-range requests
// locally with an error while keeping all responses in acceptance order.
//
// Handshake rule on every interface: a transfer happens on a cycle where
// valid && ready are both high; the sender holds valid and its payload stable
// until that cycle. dram_resp has no ready and is always accepted.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int PCN_W  = 28,
  parameter int DATA_W = 512,
  parameter int DEPTH  = 4,
  parameter logic [PCN_W:0] PCN_LIM = {1'b0, {PCN_W{1'b1}}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_req_i_valid,
  output logic              mem_req_i_ready,
  input  logic [IDX_W-1:0]  mem_req_i_bits_idx,
  input  logic              mem_req_i_bits_rnw,
  input  logic [MCN_W-1:0]  mem_req_i_bits_mcn,
  input  logic [PCN_W-1:0]  mem_req_i_bits_pcn,
  input  logic [DATA_W-1:0] mem_req_i_bits_data,
  output logic              mem_resp_o_valid,
  input  logic              mem_resp_o_ready,
  output logic [IDX_W-1:0]  mem_resp_o_bits_idx,
  output logic              mem_resp_o_bits_err,
  output logic              mem_resp_o_bits_rnw,
  output logic [DATA_W-1:0] mem_resp_o_bits_data,
  output logic              dram_req_valid,
  input  logic              dram_req_ready,
  output logic              dram_req_rnw,
  output logic [PCN_W-1:0]  dram_req_addr,
  output logic [DATA_W-1:0] dram_req_data,
  input  logic              dram_resp_valid,
  input  logic [DATA_W-1:0] dram_resp_data,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int TRK_W = IDX_W + TRK_META_W;

  logic              req_err;
  logic              req_fire;
  logic              resp_fire;
  logic              trk_full;
  logic              trk_empty;
  logic              dat_empty;
  logic              dat_full_unused;
  logic              mcn_unused;
  logic [TRK_W-1:0]  trk_push_data;
  logic [TRK_W-1:0]  trk_head;
  trk_meta_t         push_meta;
  trk_meta_t         head_meta;
  logic [IDX_W-1:0]  head_idx;
  logic [DATA_W-1:0] dat_head;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // The Midgard line number plays no part in the physical access.
  assign mcn_unused = ^mem_req_i_bits_mcn;

  // Request side: out-of-range lines are answered locally, never forwarded.
  // A full tracker blocks acceptance even if a response leaves this cycle,
  // which keeps ready free of any path from mem_resp_o_ready.
  assign req_err         = ({1'b0, mem_req_i_bits_pcn} >= PCN_LIM);
  assign mem_req_i_ready = !trk_full && (req_err || dram_req_ready);
  assign dram_req_valid  = mem_req_i_valid && !req_err && !trk_full;
  assign req_fire        = mem_req_i_valid && mem_req_i_ready;
  assign dram_req_rnw    = dram_req_valid && mem_req_i_bits_rnw;
  assign dram_req_addr   = dram_req_valid ? mem_req_i_bits_pcn  : '0;
  assign dram_req_data   = dram_req_valid ? mem_req_i_bits_data : '0;

  assign push_meta     = '{rnw: mem_req_i_bits_rnw, err: req_err};
  assign trk_push_data = {mem_req_i_bits_idx, push_meta};
  assign {head_idx, head_meta} = trk_head;

  // Response side: an error head needs no DRAM data, so it can leave as soon
  // as it reaches the head of the tracker.
  assign mem_resp_o_valid     = !trk_empty && (head_meta.err || !dat_empty);
  assign resp_fire            = mem_resp_o_valid && mem_resp_o_ready;
  assign mem_resp_o_bits_idx  = mem_resp_o_valid ? head_idx : '0;
  assign mem_resp_o_bits_err  = mem_resp_o_valid && head_meta.err;
  assign mem_resp_o_bits_rnw  = mem_resp_o_valid && head_meta.rnw;
  assign mem_resp_o_bits_data = (mem_resp_o_valid && !head_meta.err) ? dat_head : '0;

  // Every accepted request, good or bad, holds its place in line here.
  mem_bridge_fifo #(.W(TRK_W), .DEPTH(DEPTH)) u_trk_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (req_fire),
    .pop_i   (resp_fire),
    .data_i  (trk_push_data),
    .data_o  (trk_head),
    .full_o  (trk_full),
    .empty_o (trk_empty)
  );

  // DRAM data in DRAM order; cannot overflow because outstanding <= DEPTH.
  mem_bridge_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_dat_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (dram_resp_valid),
    .pop_i   (resp_fire && !head_meta.err),
    .data_i  (dram_resp_data),
    .data_o  (dat_head),
    .full_o  (dat_full_unused),
    .empty_o (dat_empty)
  );

  // Saturating count of accepted out-of-range requests.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (req_fire && req_err && (err_cnt_q != ERR_CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Error counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

endmodule
